// File: rtl/hdmi_video_timing_ctrl.sv
// Raster timing generator for a TMDS transmitter. It produces de, hsync and vsync for a programmable raster,
// pulls RGB pixels over ready/valid, and registers everything so the three encoders see aligned data.
module hdmi_video_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        i_pixclk,
  input  logic        i_reset_n,
  input  logic        i_enable,
  input  logic        i_pix_valid,
  input  logic [23:0] i_pix_rgb,
  output logic        o_pix_ready,
  output logic        o_de,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic [7:0]  o_red,
  output logic [7:0]  o_green,
  output logic [7:0]  o_blue,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_frame_start,
  output logic        o_underflow,
  output logic        o_busy
);

  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_S = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_E = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_S = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_E = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  state_e      state_q, state_d;
  logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic        de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic        frame_start_q, frame_start_d, underflow_q, underflow_d, busy_q, busy_d;
  logic [23:0] pix_q, pix_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic        running, active, h_wrap, v_wrap;

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    running = (state_q != ST_IDLE);
    h_wrap  = (h_cnt_q == H_LAST);
    v_wrap  = (v_cnt_q == V_LAST);

    if (running) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 12'd1;
      if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + 12'd1;
    end else begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end

    unique case (state_q)
      ST_IDLE:  if (i_enable) state_d = ST_RUN;
      ST_RUN:   if (!i_enable) state_d = ST_DRAIN;
      ST_DRAIN: if (h_wrap && v_wrap) state_d = i_enable ? ST_RUN : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs describe the current counter position and show up one cycle later.
    active        = running && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    o_pix_ready   = active;
    de_d          = active;
    pix_d         = (active && i_pix_valid) ? i_pix_rgb : '0;
    underflow_d   = active && !i_pix_valid;
    x_d           = active ? h_cnt_q : '0;
    y_d           = active ? v_cnt_q : '0;
    hsync_d       = (running && h_cnt_q >= H_SYNC_S && h_cnt_q < H_SYNC_E) ? HS_POL : ~HS_POL;
    vsync_d       = (running && v_cnt_q >= V_SYNC_S && v_cnt_q < V_SYNC_E) ? VS_POL : ~VS_POL;
    frame_start_d = running && (h_cnt_q == '0) && (v_cnt_q == '0);
    busy_d        = (state_d != ST_IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= ST_IDLE;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      de_q          <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      pix_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      pix_q         <= pix_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
      busy_q        <= busy_d;
    end
  end

  assign o_de          = de_q;
  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_red         = pix_q[23:16];
  assign o_green       = pix_q[15:8];
  assign o_blue        = pix_q[7:0];
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_frame_start = frame_start_q;
  assign o_underflow   = underflow_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_hdmi_video_timing_ctrl.sv
// Bench for hdmi_video_timing_ctrl: a default 640x480 instance exercised over two lines and a tiny
// 8x5 raster instance for frame-level enable/drain/reset behaviour. Pixels are checked via scoreboard queues.
module tb_hdmi_video_timing_ctrl;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [23:0] rgb;
    logic        uf;
  } pix_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default-raster instance
  logic        en_d = 1'b0, valid_d = 1'b0;
  logic [23:0] rgb_d = '0;
  logic        ready_d, de_d, hs_d, vs_d, fs_d, uf_d, busy_d;
  logic [7:0]  r_d, g_d, b_d;
  logic [11:0] x_d, y_d;

  // Small-raster instance: line 8, frame 40, positive syncs
  logic        en_s = 1'b0, valid_s = 1'b0;
  logic [23:0] rgb_s = '0;
  logic        ready_s, de_s, hs_s, vs_s, fs_s, uf_s, busy_s;
  logic [7:0]  r_s, g_s, b_s;
  logic [11:0] x_s, y_s;

  hdmi_video_timing_ctrl dut_d (
    .i_pixclk(clk), .i_reset_n(rst_n), .i_enable(en_d), .i_pix_valid(valid_d), .i_pix_rgb(rgb_d),
    .o_pix_ready(ready_d), .o_de(de_d), .o_hsync(hs_d), .o_vsync(vs_d),
    .o_red(r_d), .o_green(g_d), .o_blue(b_d), .o_x(x_d), .o_y(y_d),
    .o_frame_start(fs_d), .o_underflow(uf_d), .o_busy(busy_d)
  );

  hdmi_video_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_s (
    .i_pixclk(clk), .i_reset_n(rst_n), .i_enable(en_s), .i_pix_valid(valid_s), .i_pix_rgb(rgb_s),
    .o_pix_ready(ready_s), .o_de(de_s), .o_hsync(hs_s), .o_vsync(vs_s),
    .o_red(r_s), .o_green(g_s), .o_blue(b_s), .o_x(x_s), .o_y(y_s),
    .o_frame_start(fs_s), .o_underflow(uf_s), .o_busy(busy_s)
  );

  int total = 0;
  int bad = 0;
  pix_t q_d[$];
  pix_t q_s[$];
  int ns = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic pix_t mk_pix(input int x, input int y, input logic [23:0] rgb, input logic uf);
    pix_t p;
    p.x = 12'(x); p.y = 12'(y); p.rgb = rgb; p.uf = uf;
    return p;
  endfunction

  // Monitor: every cycle a DUT presents o_de, the oldest expected pixel is popped and compared.
  always @(negedge clk) begin : monitor
    pix_t e;
    if (rst_n) begin
      if (de_d) begin
        if (q_d.size() == 0) check("d_unexpected_de", 32'd1, 32'd0);
        else begin
          e = q_d.pop_front();
          check("d_x", x_d, e.x);
          check("d_y", y_d, e.y);
          check("d_rgb", {r_d, g_d, b_d}, e.rgb);
          check("d_underflow", uf_d, e.uf);
        end
      end
      if (de_s) begin
        if (q_s.size() == 0) check("s_unexpected_de", 32'd1, 32'd0);
        else begin
          e = q_s.pop_front();
          check("s_x", x_s, e.x);
          check("s_y", y_s, e.y);
          check("s_rgb", {r_s, g_s, b_s}, e.rgb);
          check("s_underflow", uf_s, e.uf);
        end
      end
    end
  end

  // Runs the small raster for n+1 cycles; en_s must already be high. Enable is dropped at position p_drop,
  // after which the current frame completes and the block goes idle.
  task automatic run_s(input int n, input int p_drop);
    int end_p, p, h, v, hj, vj;
    logic act;
    end_p = (p_drop / 40 + 1) * 40;
    for (int j = 0; j <= n; j++) begin
      @(negedge clk);
      if (j == 0) begin
        check("s_fs_before_start", fs_s, 32'd0);
      end else begin
        p = j - 1;
        if (p < end_p) begin
          h = p % 8;
          v = (p / 8) % 5;
          check("s_de", de_s, (h < 4 && v < 2) ? 32'd1 : 32'd0);
          check("s_hsync", hs_s, (h == 5 || h == 6) ? 32'd1 : 32'd0);
          check("s_vsync", vs_s, (v == 3) ? 32'd1 : 32'd0);
          check("s_frame_start", fs_s, (p % 40 == 0) ? 32'd1 : 32'd0);
        end else begin
          check("s_idle_de", de_s, 32'd0);
          check("s_idle_hsync", hs_s, 32'd0);
          check("s_idle_vsync", vs_s, 32'd0);
          check("s_idle_fs", fs_s, 32'd0);
          check("s_idle_rgb", {r_s, g_s, b_s}, 32'd0);
        end
      end
      if (j >= 1 && j < end_p - 1) check("s_busy_run", busy_s, 32'd1);
      if (j >= end_p + 1) check("s_busy_idle", busy_s, 32'd0);
      hj = j % 8;
      vj = (j / 8) % 5;
      act = (j < end_p) && (hj < 4) && (vj < 2);
      check("s_ready", ready_s, {31'd0, act});
      if (j == p_drop) en_s = 1'b0;
      valid_s = 1'b1;
      rgb_s = {8'(ns), ~8'(ns), 8'(ns + 5)};
      if (act) begin
        q_s.push_back(mk_pix(hj, vj, rgb_s, 1'b0));
        ns++;
      end
    end
  endtask

  initial begin
    int de_cnt[2], hs_first[2], hs_last[2], hs_cnt[2];
    int vs_low, fs_cnt, uf_cnt, n, p, h, v, ln;
    logic act, val;
    for (int i = 0; i < 2; i++) begin
      de_cnt[i] = 0; hs_first[i] = -1; hs_last[i] = -1; hs_cnt[i] = 0;
    end
    vs_low = 0; fs_cnt = 0; uf_cnt = 0; n = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_d_de", de_d, 32'd0);
    check("rst_d_hsync", hs_d, 32'd1);
    check("rst_d_vsync", vs_d, 32'd1);
    check("rst_d_rgb", {r_d, g_d, b_d}, 32'd0);
    check("rst_d_xy", {x_d, y_d}, 32'd0);
    check("rst_d_fs_uf_busy", {fs_d, uf_d, busy_d}, 32'd0);
    check("rst_s_hsync", hs_s, 32'd0);
    check("rst_s_vsync", vs_s, 32'd0);
    check("rst_s_ready", ready_s, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_d_ready", ready_d, 32'd0);
    check("idle_d_busy", busy_d, 32'd0);

    // Default raster: two full lines, with a 3-pixel valid gap at h=100 of line 0
    en_d = 1'b1;
    for (int j = 0; j <= 1602; j++) begin
      @(negedge clk);
      if (j >= 1) begin
        p = j - 1;
        h = p % 800;
        ln = p / 800;
        if (ln < 2) begin
          if (de_d) de_cnt[ln]++;
          if (!hs_d) begin
            if (hs_cnt[ln] == 0) hs_first[ln] = h;
            hs_last[ln] = h;
            hs_cnt[ln]++;
          end
        end
        if (!vs_d) vs_low++;
        if (fs_d) begin
          fs_cnt++;
          check("d_fs_position", p, 32'd0);
        end
        if (uf_d) uf_cnt++;
      end
      h = j % 800;
      v = j / 800;
      act = (h < 640) && (v < 480);
      check("d_ready", ready_d, {31'd0, act});
      val = !(v == 0 && h >= 100 && h <= 102);
      valid_d = val;
      rgb_d = 24'(n);
      if (act) begin
        q_d.push_back(mk_pix(h, v, val ? 24'(n) : 24'd0, !val));
        if (val) n++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      check("d_de_per_line", de_cnt[i], 32'd640);
      check("d_hsync_first", hs_first[i], 32'd656);
      check("d_hsync_last", hs_last[i], 32'd751);
      check("d_hsync_width", hs_cnt[i], 32'd96);
    end
    check("d_vsync_low_early_lines", vs_low, 32'd0);
    check("d_frame_start_count", fs_cnt, 32'd1);
    check("d_underflow_count", uf_cnt, 32'd3);

    // Reset during active video on the default raster
    #1 rst_n = 1'b0;
    en_d = 1'b0;
    valid_d = 1'b0;
    #1;
    check("d_async_rst_de", de_d, 32'd0);
    check("d_async_rst_syncs", {hs_d, vs_d}, 32'd3);
    check("d_async_rst_rgb", {r_d, g_d, b_d}, 32'd0);
    check("d_async_rst_busy", busy_d, 32'd0);
    q_d.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Small raster: two full frames, drop enable in frame 2, drain to idle, then restart
    en_s = 1'b1;
    run_s(130, 85);
    en_s = 1'b1;
    run_s(50, 1 << 20);

    // Reset mid-line during active video on the small raster
    #1 rst_n = 1'b0;
    en_s = 1'b0;
    #1;
    check("s_async_rst_de", de_s, 32'd0);
    check("s_async_rst_rgb", {r_s, g_s, b_s}, 32'd0);
    check("s_async_rst_syncs", {hs_s, vs_s}, 32'd0);
    check("s_async_rst_ready", ready_s, 32'd0);
    check("s_async_rst_busy", busy_s, 32'd0);
    q_s.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("s_post_rst_ready", ready_s, 32'd0);
      check("s_post_rst_de", de_s, 32'd0);
    end
    en_s = 1'b1;
    run_s(12, 1 << 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
